// File: rtl/stream_out_framer.sv
// Output framer between the result stream and the DMA S2MM channel: counts beats
// against a programmed length, tags TLAST, pulses done, and registers all outputs via a 2-entry buffer.
module stream_out_framer #(
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  beat_total,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  err_start
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_total;
  logic [CNT_WIDTH-1:0]  r_in_cnt;
  logic [CNT_WIDTH-1:0]  r_beat_cnt;
  logic                  r_done;
  logic                  r_err_start;

  logic [DATA_WIDTH-1:0] r_buf_data [2];
  logic [1:0]            r_buf_last;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_occ;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_last_flag;
  logic                  w_start_ok;

  // s_ready depends only on registers, so m_ready never reaches the upstream ready path.
  assign s_ready     = (r_state == ST_RUN) && (r_in_cnt != r_total) && (r_occ != 2'd2);
  assign m_valid     = (r_occ != 2'd0);
  assign m_data      = r_buf_data[r_rd_ptr];
  assign m_last      = r_buf_last[r_rd_ptr] && m_valid;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign beat_cnt    = r_beat_cnt;
  assign err_start   = r_err_start;

  assign w_push      = s_valid && s_ready;
  assign w_pop       = m_valid && m_ready;
  assign w_last_flag = (r_in_cnt == r_total - CNT_WIDTH'(1));
  assign w_start_ok  = start && (r_state == ST_IDLE) && (beat_total != '0);

  always_comb begin
    // NOTE: default assigned first so every path drives w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_start_ok)               w_state_nxt = ST_RUN;
      ST_RUN:   if (w_push && w_last_flag)    w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_pop && m_last)          w_state_nxt = ST_IDLE;
      default:                                w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_total     <= '0;
      r_in_cnt    <= '0;
      r_beat_cnt  <= '0;
      r_done      <= 1'b0;
      r_err_start <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_push) r_in_cnt <= r_in_cnt + CNT_WIDTH'(1);
      if (w_pop && (r_beat_cnt != r_total)) r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
      if ((r_state == ST_DRAIN) && w_pop && m_last) r_done <= 1'b1;

      if (start) begin
        if (r_state != ST_IDLE) begin
          r_err_start <= 1'b1;
        end else if (beat_total == '0) begin
          r_done <= 1'b1;
        end else begin
          r_total     <= beat_total;
          r_in_cnt    <= '0;
          r_beat_cnt  <= '0;
          r_err_start <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the buffer entries are reset because the head entry is a visible output with a defined reset value.
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_last    <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_occ         <= '0;
    end else begin
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= s_data;
        r_buf_last[r_wr_ptr] <= w_last_flag;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_stream_out_framer.sv
// Directed bench for stream_out_framer: table of transfers checked against a
// small source/sink model, plus hand sequences for single-beat, zero-length and mid-transfer reset.
module tb_stream_out_framer;

  localparam int DW = 128;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          start;
  logic [CW-1:0] beat_total;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic          done;
  logic [CW-1:0] beat_cnt;
  logic          err_start;

  int n_cmp  = 0;
  int n_fail = 0;

  stream_out_framer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .aresetn(aresetn), .start(start), .beat_total(beat_total),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done), .beat_cnt(beat_cnt), .err_start(err_start)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    int          total;
    bit          toggle;   // 0: m_ready held high, 1: m_ready alternates
    int          err_cyc;  // loop cycle in which a stray start is pulsed, -1 for none
    bit          exp_err;
    logic [31:0] base;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [31:0] base, input int i);
    logic [31:0] iv;
    iv = 32'(i);
    return {base, iv, ~base, base ^ iv};
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle where done is visible.
  task automatic run_xfer(input vec_t v);
    int          in_idx = 0;
    int          out_idx = 0;
    int          occ = 0;
    int          cyc = 0;
    bit          stalled = 0;
    bit          push, pop;
    logic [DW-1:0] held = '0;
    start = 1'b1; beat_total = CW'(v.total); s_valid = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", DW'(busy), DW'(1));
    check("done_low_after_start", DW'(done), DW'(0));
    while (done !== 1'b1) begin
      if (cyc > 4 * v.total + 20) begin
        check("xfer_cycle_budget", DW'(cyc), DW'(0));
        break;
      end
      s_valid = 1'b1;
      s_data  = mk(v.base, in_idx);
      m_ready = v.toggle ? (cyc % 2 == 0) : 1'b1;
      start   = (cyc == v.err_cyc);
      beat_total = CW'(7);
      check("busy_run", DW'(busy), DW'(1));
      check("s_ready", DW'(s_ready), DW'((occ < 2) && (in_idx < v.total)));
      check("m_valid", DW'(m_valid), DW'(occ != 0));
      if (stalled) check("m_data_stable", m_data, held);
      push = s_ready && s_valid;
      pop  = m_valid && m_ready;
      if (pop) begin
        check("m_data", m_data, mk(v.base, out_idx));
        check("m_last", DW'(m_last), DW'(out_idx == v.total - 1));
        out_idx++;
      end
      stalled = m_valid && !m_ready;
      held    = m_data;
      occ     = occ + int'(push) - int'(pop);
      in_idx  = in_idx + int'(push);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("done_pulse", DW'(done), DW'(1));
    check("busy_at_done", DW'(busy), DW'(0));
    check("beats_out", DW'(out_idx), DW'(v.total));
    check("beat_cnt", DW'(beat_cnt), DW'(v.total));
    check("err_start", DW'(err_start), DW'(v.exp_err));
    check("m_valid_at_done", DW'(m_valid), DW'(0));
    if (!v.toggle) check("throughput_cycles", DW'(cyc), DW'(v.total + 1));
  endtask

  vec_t vecs [5];

  initial begin
    vec_t hv;
    vecs[0] = '{total: 4,  toggle: 0, err_cyc: -1, exp_err: 0, base: 32'h1000_0000};
    vecs[1] = '{total: 8,  toggle: 1, err_cyc: -1, exp_err: 0, base: 32'h2000_0000};
    vecs[2] = '{total: 16, toggle: 0, err_cyc: 5,  exp_err: 1, base: 32'h3000_0000};
    vecs[3] = '{total: 2,  toggle: 1, err_cyc: -1, exp_err: 0, base: 32'h4000_0000};
    vecs[4] = '{total: 5,  toggle: 0, err_cyc: -1, exp_err: 0, base: 32'h5000_0000};

    aresetn = 1'b0; start = 1'b0; beat_total = '0; s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
    #1;
    check("rst_s_ready", DW'(s_ready), DW'(0));
    check("rst_m_valid", DW'(m_valid), DW'(0));
    check("rst_m_last", DW'(m_last), DW'(0));
    check("rst_m_data", m_data, '0);
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_beat_cnt", DW'(beat_cnt), DW'(0));
    check("rst_err_start", DW'(err_start), DW'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) aresetn = 1'b1;
    @(posedge clk); #1;

    // Back-to-back transfers: each new start coincides with the previous done pulse.
    for (int i = 0; i < 5; i++) run_xfer(vecs[i]);

    // Single beat, then the next upstream beat must be held off.
    hv = '{total: 1, toggle: 0, err_cyc: -1, exp_err: 0, base: 32'h6000_0000};
    run_xfer(hv);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_s_ready", DW'(s_ready), DW'(0));
      check("hold_m_valid", DW'(m_valid), DW'(0));
    end

    // Zero-length transfer.
    start = 1'b1; beat_total = '0;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done", DW'(done), DW'(1));
    check("zero_busy", DW'(busy), DW'(0));
    check("zero_m_valid", DW'(m_valid), DW'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("zero_done_off", DW'(done), DW'(0));
      check("zero_quiet", DW'({busy, m_valid}), DW'(0));
    end

    // Reset after 3 of 10 beats.
    start = 1'b1; beat_total = CW'(10);
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; m_ready = 1'b1; s_data = mk(32'h7000_0000, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      s_data = mk(32'h7000_0000, i + 1);
    end
    check("mid_beat_cnt", DW'(beat_cnt), DW'(3));
    check("mid_m_valid", DW'(m_valid), DW'(1));
    #2 aresetn = 1'b0;
    #1;
    check("arst_m_valid", DW'(m_valid), DW'(0));
    check("arst_s_ready", DW'(s_ready), DW'(0));
    check("arst_busy", DW'(busy), DW'(0));
    check("arst_done", DW'(done), DW'(0));
    check("arst_beat_cnt", DW'(beat_cnt), DW'(0));
    check("arst_m_data", m_data, '0);
    @(negedge clk) aresetn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_done", DW'(done), DW'(0));
    check("post_rst_m_valid", DW'(m_valid), DW'(0));
    hv = '{total: 2, toggle: 0, err_cyc: -1, exp_err: 0, base: 32'h8000_0000};
    run_xfer(hv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
